// File: rtl/video_timing_monitor.sv
// Measures line and frame timing from blanking/sync strobes and publishes
// frame-coherent totals, with a stability lock and a no-line watchdog.
module video_timing_monitor #(
    parameter int STABLE_FRAMES = 3,
    parameter int TIMEOUT_CLKS  = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       hbl,
    input  logic       hsync,
    input  logic       vbl,
    input  logic       vsync,
    output logic [9:0] h_total,
    output logic [9:0] h_active,
    output logic [9:0] hs_width,
    output logic [9:0] v_total,
    output logic [9:0] v_active,
    output logic [9:0] vs_width,
    output logic       new_frame,
    output logic       locked,
    output logic       timeout
);
    localparam int WDW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CLKS - 1);
    localparam logic [WDW-1:0] WD_FULL  = WDW'(TIMEOUT_CLKS);
    localparam logic [3:0]     STABLE_N = 4'(STABLE_FRAMES);
    localparam logic [9:0]     CNT_MAX  = 10'd1023;

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_ALIGN   = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

    logic           prev_hbl_q, prev_hbl_d;
    logic           vbl_at_lb_q, vbl_at_lb_d;
    logic [9:0]     hcnt_q, hcnt_d, hact_q, hact_d, hsw_q, hsw_d;
    logic [9:0]     vcnt_q, vcnt_d, vact_q, vact_d, vsw_q, vsw_d;
    logic [1:0]     state_q, state_d;
    logic [3:0]     stable_q, stable_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic [9:0]     h_total_q, h_total_d, h_active_q, h_active_d, hs_width_q, hs_width_d;
    logic [9:0]     v_total_q, v_total_d, v_active_q, v_active_d, vs_width_q, vs_width_d;
    logic           new_frame_q, new_frame_d, locked_q, locked_d, timeout_q, timeout_d;

    logic        lb, fb, wd_hit, publish;
    logic [59:0] meas_tuple, held_tuple;

    assign lb      = ce & ~hbl & prev_hbl_q;
    assign fb      = lb & ~vbl & vbl_at_lb_q;
    // A line boundary on the threshold cycle takes priority over the watchdog.
    assign wd_hit  = ~lb & (wd_q >= WD_LAST);
    assign publish = fb & (state_q == ST_MEASURE);

    assign meas_tuple = {sat_inc(hcnt_q), hact_q, hsw_q, vcnt_q, vact_q, vsw_q};
    assign held_tuple = {h_total_q, h_active_q, hs_width_q, v_total_q, v_active_q, vs_width_q};

    always_comb begin
        prev_hbl_d  = prev_hbl_q;
        vbl_at_lb_d = vbl_at_lb_q;
        hcnt_d      = hcnt_q;
        hact_d      = hact_q;
        hsw_d       = hsw_q;
        vcnt_d      = vcnt_q;
        vact_d      = vact_q;
        vsw_d       = vsw_q;
        state_d     = state_q;
        stable_d    = stable_q;
        wd_d        = wd_q;
        {h_total_d, h_active_d, hs_width_d, v_total_d, v_active_d, vs_width_d} = held_tuple;
        new_frame_d = 1'b0;
        locked_d    = locked_q;
        timeout_d   = timeout_q;

        if (ce) begin
            prev_hbl_d = hbl;
            if (lb) begin
                hcnt_d      = 10'd0;
                hact_d      = 10'd1;
                hsw_d       = {9'd0, ~hsync};
                vbl_at_lb_d = vbl;
                if (fb) begin
                    vcnt_d = 10'd1;
                    vact_d = 10'd1;
                    vsw_d  = {9'd0, ~vsync};
                end else begin
                    vcnt_d = sat_inc(vcnt_q);
                    vact_d = vbl   ? vact_q : sat_inc(vact_q);
                    vsw_d  = vsync ? vsw_q  : sat_inc(vsw_q);
                end
            end else begin
                hcnt_d = sat_inc(hcnt_q);
                hact_d = hbl   ? hact_q : sat_inc(hact_q);
                hsw_d  = hsync ? hsw_q  : sat_inc(hsw_q);
            end
        end

        if (lb) begin
            wd_d      = '0;
            timeout_d = 1'b0;
            case (state_q)
                ST_SEARCH:  state_d = ST_ALIGN;
                ST_ALIGN:   if (fb) state_d = ST_MEASURE;
                ST_MEASURE: state_d = ST_MEASURE;
                default:    state_d = ST_SEARCH;
            endcase
        end else if (wd_hit) begin
            wd_d      = WD_FULL;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            stable_d  = 4'd0;
            state_d   = ST_SEARCH;
        end else begin
            wd_d = wd_q + WDW'(1);
        end

        if (publish) begin
            {h_total_d, h_active_d, hs_width_d, v_total_d, v_active_d, vs_width_d} = meas_tuple;
            new_frame_d = 1'b1;
            if (meas_tuple == held_tuple)
                stable_d = (stable_q >= STABLE_N) ? STABLE_N : stable_q + 4'd1;
            else
                stable_d = 4'd0;
            locked_d = (stable_d == STABLE_N);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_hbl_q  <= 1'b0;
            vbl_at_lb_q <= 1'b0;
            hcnt_q      <= '0;
            hact_q      <= '0;
            hsw_q       <= '0;
            vcnt_q      <= '0;
            vact_q      <= '0;
            vsw_q       <= '0;
            state_q     <= ST_SEARCH;
            stable_q    <= '0;
            wd_q        <= '0;
            h_total_q   <= '0;
            h_active_q  <= '0;
            hs_width_q  <= '0;
            v_total_q   <= '0;
            v_active_q  <= '0;
            vs_width_q  <= '0;
            new_frame_q <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            prev_hbl_q  <= prev_hbl_d;
            vbl_at_lb_q <= vbl_at_lb_d;
            hcnt_q      <= hcnt_d;
            hact_q      <= hact_d;
            hsw_q       <= hsw_d;
            vcnt_q      <= vcnt_d;
            vact_q      <= vact_d;
            vsw_q       <= vsw_d;
            state_q     <= state_d;
            stable_q    <= stable_d;
            wd_q        <= wd_d;
            h_total_q   <= h_total_d;
            h_active_q  <= h_active_d;
            hs_width_q  <= hs_width_d;
            v_total_q   <= v_total_d;
            v_active_q  <= v_active_d;
            vs_width_q  <= vs_width_d;
            new_frame_q <= new_frame_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    assign h_total   = h_total_q;
    assign h_active  = h_active_q;
    assign hs_width  = hs_width_q;
    assign v_total   = v_total_q;
    assign v_active  = v_active_q;
    assign vs_width  = vs_width_q;
    assign new_frame = new_frame_q;
    assign locked    = locked_q;
    assign timeout   = timeout_q;
endmodule
